conv_mac: RTL and testbench

CONV_MAC -- requirements
Module: conv_mac

---
 rtl/conv_mac.sv | 151 +++++++++++++++
 tb/tb_conv_mac.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/conv_mac.sv
// conv_mac: 3x3 convolution multiply-accumulate for one output pixel.
// Each beat carries a 3x3 activation window and its kernel. Beats go through
// a multiply stage, an adder-tree stage and an accumulate stage. The finished
// pixel is rescaled, the bias is added, optional ReLU is applied, and the
// value is saturated to the activation width.
//
// state | meaning
// IDLE  | waiting for start
// ACCUM | accepting beats until beat num_c_m1 has been accepted
// DRAIN | letting the last beat reach the accumulator (3 cycles)
// OUT   | result valid for one cycle
module conv_mac #(
    parameter int DATSIZE = 22,
    parameter int PARSIZE = 16,
    parameter int FPSHIFT = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [5:0]             num_c_m1,
    input  logic                   relu_en,
    input  logic                   valid_in,
    input  logic [9*DATSIZE-1:0]   window,
    input  logic [9*PARSIZE-1:0]   weights,
    input  logic [PARSIZE-1:0]     bias,
    output logic                   ready,
    output logic                   busy,
    output logic                   valid_out,
    output logic [DATSIZE-1:0]     result
);

    localparam int PW   = DATSIZE + PARSIZE;
    localparam int SW   = PW + 4;
    localparam int ACCW = 48;
    localparam logic signed [ACCW-1:0] SAT_MAX = (48'sd1 <<< (DATSIZE - 1)) - 48'sd1;
    localparam logic signed [ACCW-1:0] SAT_MIN = -(48'sd1 <<< (DATSIZE - 1));

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

    state_t state, state_nxt;

    logic                      accept;
    logic                      start_acc;
    logic                      last_beat;
    logic                      drain_done;
    logic [1:0]                drain_cnt;
    logic [5:0]                beat_cnt;
    logic [5:0]                num_c_m1_q;
    logic                      relu_q;
    logic signed [PARSIZE-1:0] bias_q;
    logic                      v1, v2;
    logic signed [PW-1:0]      prod [9];
    logic signed [SW-1:0]      psum, sum_q;
    logic signed [ACCW-1:0]    acc;
    logic signed [ACCW-1:0]    scaled, relu_val;
    logic [DATSIZE-1:0]        sat_val;

    assign accept     = valid_in && (state == ACCUM);
    assign start_acc  = start && (state == IDLE);
    assign last_beat  = accept && (beat_cnt == num_c_m1_q);
    assign drain_done = (state == DRAIN) && (drain_cnt == 2'd2);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)      state_nxt = ACCUM;
            ACCUM:   if (last_beat)  state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = OUT;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        ready     = (state == ACCUM);
        busy      = (state != IDLE);
        valid_out = (state == OUT);
    end

    // Control: config latch, beat counter, drain timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_c_m1_q <= '0;
            relu_q     <= 1'b0;
            bias_q     <= '0;
            beat_cnt   <= '0;
            drain_cnt  <= '0;
        end else begin
            if (start_acc) begin
                num_c_m1_q <= num_c_m1;
                relu_q     <= relu_en;
                bias_q     <= $signed(bias);
                beat_cnt   <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 6'd1;
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
        end
    end

    // Adder tree over the nine registered products
    always_comb begin
        psum = '0;
        for (int k = 0; k < 9; k++) psum = psum + SW'(prod[k]);
    end

    // Three-stage datapath: multiply, sum, accumulate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            sum_q <= '0;
            acc   <= '0;
            for (int k = 0; k < 9; k++) prod[k] <= '0;
        end else begin
            v1 <= accept;
            v2 <= v1;
            if (accept) begin
                for (int k = 0; k < 9; k++)
                    prod[k] <= $signed(window[k*DATSIZE +: DATSIZE]) *
                               $signed(weights[k*PARSIZE +: PARSIZE]);
            end
            if (v1) sum_q <= psum;
            if (start_acc)  acc <= '0;
            else if (v2)    acc <= acc + ACCW'(sum_q);
        end
    end

    // Rescale, add bias, optional ReLU, saturate to activation range
    always_comb begin
        scaled   = (acc >>> FPSHIFT) + ACCW'(bias_q);
        relu_val = (relu_q && scaled < 0) ? '0 : scaled;
        if (relu_val > SAT_MAX)      sat_val = SAT_MAX[DATSIZE-1:0];
        else if (relu_val < SAT_MIN) sat_val = SAT_MIN[DATSIZE-1:0];
        else                         sat_val = relu_val[DATSIZE-1:0];
    end

    // Result register, loaded as the FSM enters OUT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          result <= '0;
        else if (drain_done) result <= sat_val;
    end

endmodule

// File: tb/tb_conv_mac.sv
module tb_conv_mac;

    localparam int D = 22;
    localparam int P = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [5:0]     num_c_m1 = '0;
    logic           relu_en = 1'b0;
    logic           valid_in = 1'b0;
    logic [9*D-1:0] window = '0;
    logic [9*P-1:0] weights = '0;
    logic [P-1:0]   bias = '0;
    logic           ready, busy, valid_out;
    logic [D-1:0]   result;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    longint exp_val_q[$];
    int     exp_cyc_q[$];

    conv_mac dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_c_m1(num_c_m1),
        .relu_en(relu_en), .valid_in(valid_in), .window(window),
        .weights(weights), .bias(bias), .ready(ready), .busy(busy),
        .valid_out(valid_out), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pop expected result whenever the DUT strobes valid_out
    always @(negedge clk) begin
        if (rst_n && valid_out) begin
            if (exp_val_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid_out: got result %0d expected no strobe", $signed(result));
            end else begin
                longint ev;
                int ec;
                ev = exp_val_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("result", longint'($signed(result)), ev);
                check("latency", cyc, ec);
            end
        end
    end

    function automatic longint ref_pixel(input longint acc, input bit relu, input longint b);
        longint v;
        v = (acc >>> 14) + b;
        if (relu && v < 0) v = 0;
        if (v > 2097151) v = 2097151;
        if (v < -2097152) v = -2097152;
        return v;
    endfunction

    // One pixel: rnd selects random taps, otherwise all taps xv/wv
    task automatic run_pixel(input int nc, input bit relu, input int bias_v,
                             input bit rnd, input int xv, input int wv,
                             input bit gaps, input bit mid_start);
        longint acc = 0;
        int t_last = 0;
        logic signed [D-1:0] xs;
        logic signed [P-1:0] ws;
        logic [P-1:0] bvec;
        bvec = bias_v[P-1:0];
        @(posedge clk); #1;
        start = 1'b1; num_c_m1 = 6'(nc); relu_en = relu; bias = bvec; valid_in = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; num_c_m1 = 6'($urandom); relu_en = ~relu; bias = P'($urandom);
        for (int b = 0; b <= nc; b++) begin
            if (gaps && b > 0) begin
                valid_in = 1'b0;
                window = {7{$urandom}};
                if (mid_start) start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            for (int k = 0; k < 9; k++) begin
                xs = rnd ? D'($urandom) : D'(xv);
                ws = rnd ? P'($urandom) : P'(wv);
                window[k*D +: D] = xs;
                weights[k*P +: P] = ws;
                acc += longint'(xs) * longint'(ws);
            end
            valid_in = 1'b1;
            check("ready_accum", ready, 1);
            t_last = cyc;
            @(posedge clk); #1;
        end
        exp_val_q.push_back(ref_pixel(acc, relu, longint'($signed(bvec))));
        exp_cyc_q.push_back(t_last + 4);
        // Extra beats after the last one must be ignored
        window = {7{$urandom}};
        check("ready_drain", ready, 0);
        check("busy_drain", busy, 1);
        @(posedge clk); #1;
        valid_in = 1'b0;
        while (cyc < t_last + 6) begin
            @(posedge clk); #1;
        end
        check("idle_after", busy, 0);
    endtask

    initial begin
        #1;
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_valid_out", valid_out, 0);
        check("rst_result", result, 0);
        #20 rst_n = 1'b1;

        run_pixel(0, 1, 0, 0, 16384, 16384, 0, 0);
        run_pixel(0, 1, 0, 0, 16384, -16384, 0, 0);
        run_pixel(0, 0, 0, 0, 16384, -16384, 0, 0);
        run_pixel(15, 1, 0, 0, 65536, 16384, 0, 0);
        run_pixel(15, 0, 0, 0, 65536, -16384, 0, 0);
        run_pixel(3, 1, 8192, 0, 16384, 16384, 1, 1);

        // Reset after 2 of 4 beats: partial sum discarded, no strobe
        @(posedge clk); #1;
        start = 1'b1; num_c_m1 = 6'd3; relu_en = 1'b1; bias = '0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            window[k*D +: D] = D'(16384);
            weights[k*P +: P] = P'(16384);
        end
        valid_in = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("abort_ready", ready, 0);
        check("abort_busy", busy, 0);
        check("abort_valid_out", valid_out, 0);
        check("abort_result", result, 0);
        valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("post_abort_busy", busy, 0);

        run_pixel(0, 1, 0, 0, 16384, 16384, 0, 0);

        for (int i = 0; i < 25; i++)
            run_pixel($urandom_range(0, 7), 1'($urandom), int'($urandom),
                      1, 0, 0, 1'($urandom), 1'($urandom));

        repeat (4) @(posedge clk);
        check("scoreboard_drained", exp_val_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no completion expected finish before limit");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

endmodule
